seq_shifter: RTL and testbench
==============================

# seq_shifter

Parametrised multi-cycle shifter for the KGP_RISC datapath. It generalises the fixed "shift left by 2" used for branch-offset scaling to any width, any shift amount, and four shift modes. It processes at most STEP bit positions per cycle and uses a valid/ready handshake on both input and output. The ALU and branch-target path use it when a full single-cycle barrel shifter is too large.

## Interface
- WIDTH, 32, data width in bits; power of 2, ≥ 8.
- STEP, 4, maximum bit positions shifted per cycle; power of 2, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W (localparam), $clog2(WIDTH), width of the shift amount.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_valid  in  1  request present.
- start_ready  out  1  block can accept a request (IDLE).
- op  in  2  mode: 00 sll, 01 srl, 10 sra, 11 rol.
- in_data  in  WIDTH  operand.
- shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- out_data  out  WIDTH  result, registered.
- busy  out  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- start_ready = (state == IDLE).
- out_valid = (state == DONE).
- busy = (state != IDLE).
- IDLE:
  - On start_valid && start_ready, latch in_data into the data register, op into the op register, and shamt into the remaining-count register rem.
  - Next state is SHIFT if shamt ≠ 0, otherwise DONE.
- SHIFT: each edge, let s = min(STEP, rem).
  - The data register is shifted by s per op.
  - rem becomes rem − s.
  - Go to DONE when rem − s == 0; otherwise stay in SHIFT.
- Shift rules per step:
  - sll: zero-fill from the LSB.
  - srl: zero-fill from the MSB.
  - sra: fill with the original bit WIDTH-1 (the sign bit is preserved each step).
  - rol: bits leaving the MSB re-enter at the LSB.
- All arithmetic stays within WIDTH bits. Bits shifted out are discarded, except in rol.
- DONE:
  - out_data holds the result.
  - Move to IDLE on out_ready. Otherwise hold out_data and out_valid stable indefinitely.
- Inputs are ignored outside the accepting edge. Changing in_data, op or shamt mid-operation has no effect.
- start_valid while busy: not accepted. The requester must hold it until start_ready.
- Reset (any time, including mid-shift or in DONE):
  - state goes to IDLE and rem to 0.
  - out_data = 0, out_valid = 0, busy = 0, start_ready = 1.
  - The in-flight operation is discarded. No partial result is presented.
- out_data keeps its last value after returning to IDLE until the next accepted request overwrites the data register.

## Timing
- Latency from the accept edge to out_valid high is 1 + ceil(shamt/STEP) cycles.
  - shamt = 0: 1 cycle.
  - WIDTH=32, STEP=4, shamt=31: 9 cycles.
- Throughput: one result per 2 + ceil(shamt/STEP) cycles when out_ready is held high. DONE→IDLE takes one edge; there is no back-to-back accept in the DONE cycle.
- Simultaneous out_ready in DONE and start_valid: the result is consumed on that edge. The new request is accepted on the next edge (in IDLE).
- out_valid is asserted and out_data is stable from the same edge. There is no combinational path from inputs to outputs except start_ready and out_valid, which are derived from state only.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → out_valid=0, out_data=0x00000000, busy=0, start_ready=1. Release and check IDLE.
- sll legacy check: in_data=0x80000001, op=00, shamt=2 → out_data=0x00000004, out_valid 2 cycles after accept.
- sra with maximum shift: in_data=0x80000000, op=10, shamt=31 → 0xFFFFFFFF after 9 cycles. Then srl 0xF0000000 by 28 → 0x0000000F after 8 cycles.
- rol and zero amount: rol 0x80000001 by 4 → 0x00000018 (latency 2). sll 0x12345678 by 0 → 0x12345678 (latency 1).
- Backpressure and busy requests:
  - Hold out_ready=0 for 5 cycles in DONE → out_data and out_valid stable.
  - Assert start_valid with a different operand while busy → start_ready=0 and the request is not accepted.
  - Release out_ready → IDLE, then the pending request is accepted.
- Mid-operation reset: pull rst_n low asynchronously (between clock edges) 3 cycles into sra 0x80000000 by 31 → outputs go to reset values immediately. A following sll 0x1 by 5 yields 0x00000020 with a clean latency of 3.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter, at most STEP bit positions per cycle.
// Modes sll/srl/sra/rol with valid/ready handshakes on request and result.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [SHAMT_W:0] STEP_C =
    (SHAMT_W+1)'(STEP);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   data_q;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] rem_q;

  logic               accept;
  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W:0]   step_amt;
  logic [SHAMT_W-1:0] rem_nxt;
  logic [WIDTH-1:0]   shifted;

  function automatic logic [WIDTH-1:0] shift_k(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       o,
    input int               k
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill;
    fill = {WIDTH{d[WIDTH-1]}};
    r    = d;
    unique case (1'b1)
      (o == OP_SLL): r = d << k;
      (o == OP_SRL): r = d >> k;
      (o == OP_SRA): r = (d >> k) | (fill << (WIDTH - k));
      (o == OP_ROL): r = (d << k) | (d >> (WIDTH - k));
      default:       r = d;
    endcase
    return r;
  endfunction

  assign start_ready = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign out_data    = data_q;
  assign accept      = start_valid && start_ready;

  // Step is min(STEP, rem); rem never exceeds WIDTH-1 so it fits SHAMT_W.
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    step_amt = (rem_ext > STEP_C) ? STEP_C : rem_ext;
    rem_nxt  = rem_q - step_amt[SHAMT_W-1:0];
  end

  always_comb begin
    shifted = data_q;
    for (int k = 1; k <= STEP; k++) begin
      if (step_amt == (SHAMT_W+1)'(k)) begin
        shifted = shift_k(data_q, op_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rem_nxt == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      op_q   <= OP_SLL;
      rem_q  <= '0;
    end else if (accept) begin
      data_q <= in_data;
      op_q   <= op;
      rem_q  <= shamt;
    end else if (state_q == S_SHIFT) begin
      data_q <= shifted;
      rem_q  <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed vectors, scoreboard queue filled on accept,
// drained by a monitor whenever a result is consumed.
module tb_seq_shifter;

  localparam int WIDTH = 32;
  localparam int SW    = 5;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  seq_shifter #(.WIDTH(WIDTH), .STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .op         (op),
    .in_data    (in_data),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          valid_cyc = -1;
  logic [31:0] pend_data = '0;
  int          pend_lat = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n && start_valid && start_ready) begin
      q.push_back('{pend_data, pend_lat, cyc});
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (valid_cyc < 0) valid_cyc = cyc;
      if (out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none",
                   out_data);
        end else begin
          e = q.pop_front();
          check("result", out_data, e.data);
          check("latency", valid_cyc - e.acc + 1, e.lat);
        end
        valid_cyc = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] o,
                      input logic [SW-1:0] sh,
                      input logic [31:0] exp, input int lat);
    int c0;
    c0 = acc_cnt;
    pend_data = exp;
    pend_lat = lat;
    in_data = d;
    op = o;
    shamt = sh;
    start_valid = 1'b1;
    for (int i = 0; i < 100 && acc_cnt == c0; i++) tick();
    if (acc_cnt == c0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got none expected accept");
    end
    start_valid = 1'b0;
    in_data = $urandom;
    op = 2'($urandom);
    shamt = SW'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || busy); i++) tick();
    if (q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    logic [31:0] snap;
    rst_n = 1'b0;
    start_valid = 1'b0;
    out_ready = 1'b1;
    op = SLL;
    in_data = '0;
    shamt = '0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    check("idle_start_ready", 32'(start_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    send(32'h80000001, SLL, 5'd2, 32'h00000004, 2);  drain();
    send(32'h80000000, SRA, 5'd31, 32'hFFFFFFFF, 9); drain();
    send(32'hF0000000, SRL, 5'd28, 32'h0000000F, 8); drain();
    send(32'h80000001, ROL, 5'd4, 32'h00000018, 2);  drain();
    send(32'h12345678, SLL, 5'd0, 32'h12345678, 1);  drain();
    send(32'h80000000, SRL, 5'd31, 32'h00000001, 9); drain();
    send(32'h12345678, ROL, 5'd8, 32'h34567812, 3);  drain();
    send(32'h7FFFFFF0, SRA, 5'd4, 32'h07FFFFFF, 2);  drain();
    send(32'h80000010, SRA, 5'd5, 32'hFC000000, 3);  drain();
    check("idle_hold_data", out_data, 32'hFC000000);

    out_ready = 1'b0;
    send(32'h00000001, SLL, 5'd3, 32'h00000008, 2);
    for (int i = 0; i < 50 && !out_valid; i++) tick();
    snap = out_data;
    check("bp_data", snap, 32'h00000008);
    c0 = acc_cnt;
    pend_data = 32'h00000052;
    pend_lat = 2;
    in_data = 32'h000000A5;
    op = SRL;
    shamt = 5'd1;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_stable", out_data, snap);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      check("bp_no_accept", acc_cnt, c0);
    end
    out_ready = 1'b1;
    tick();
    check("release_idle", 32'(start_ready), 32'd1);
    check("release_no_b2b", acc_cnt, c0);
    tick();
    check("pending_accept", acc_cnt, c0 + 1);
    check("pending_busy", 32'(busy), 32'd1);
    start_valid = 1'b0;
    drain();

    send(32'h80000000, SRA, 5'd31, 32'hFFFFFFFF, 9);
    repeat (2) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data", out_data, 32'h0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_start_ready", 32'(start_ready), 32'd1);
    q.delete();
    valid_cyc = -1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    send(32'h00000001, SLL, 5'd5, 32'h00000020, 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
